wb_stage_q: RTL
===============

Name: wb_stage_q

Overview:
- Parametrised write-back stage for the RV32 core, sitting between the memory stage and the register-file write port.
- Selects the result source: ALU, load, PC+4 or immediate.
- Aligns and sign/zero-extends load data.
- Buffers retiring instructions in a small FIFO so the memory stage can run ahead when the register-file port stalls.
- Drives a registered write port and forwarding bus, and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; must be 32 for this load-alignment logic.
- RF_AW, 5, register address width (32 registers).
- Q_DEPTH, 4, retire FIFO depth; power of two, at least 2.
- RET_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_rd  in  RF_AW  destination register.
- in_reg_write  in  1  instruction writes rd.
- in_wb_sel  in  2  result source: 00 ALU, 01 LOAD, 10 PC4, 11 IMM.
- in_alu_result  in  XLEN  ALU output.
- in_load_data  in  XLEN  raw aligned word from data memory.
- in_ld_funct3  in  3  load type.
- in_ld_offset  in  2  byte address bits [1:0].
- in_pc_plus4  in  XLEN  link value.
- in_imm  in  XLEN  LUI immediate.
- rf_stall  in  1  register-file port busy; hold the queue head.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  RF_AW  write address (registered).
- rf_wdata  out  XLEN  write data (registered).
- fwd_valid  out  1  equals rf_we.
- fwd_rd  out  RF_AW  equals rf_waddr.
- fwd_data  out  XLEN  equals rf_wdata.
- q_level  out  clog2(Q_DEPTH)+1  FIFO occupancy.
- retire_count  out  RET_W  number of retired instructions.

Behaviour:
- Reset: rst==0 at a clk edge clears FIFO pointers and level, rf_we, rf_waddr, rf_wdata and retire_count to 0.
  - in_ready = rst && (q_level != Q_DEPTH), so in_ready is 0 while rst is low.
  - Reset mid-operation discards every queued entry, with no writes and no count.
- Result is computed combinationally at enqueue and stored as {we, rd, data}. The stored we = in_reg_write && (in_rd != 0) && legal load.
- Load extension, with byte lane = offset*8 and half lane = offset[1]*16:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half.
  - 010 LW: full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half.
  - LH/LHU with offset[0]=1: use the half selected by offset[1]; misalignment is trapped upstream.
  - funct3 011/110/111 with sel=LOAD: data=0, we=0.
- Dequeue: when q_level>0 and rf_stall==0, the head pops at the edge and loads the output register. rf_we equals the head's we bit.
- Otherwise, at that edge: rf_we<=0, and rf_waddr/rf_wdata hold their previous values.
- Latency: with the queue empty and no stall, an entry accepted at edge k drives rf_* during the cycle after edge k+1. Throughput is 1 per cycle.
- Simultaneous enqueue and dequeue: level unchanged; pointers both advance and wrap modulo Q_DEPTH.
- in_ready is computed from the current level. When full, no enqueue happens even if a dequeue occurs the same cycle.
- retire_count increments by 1 for every dequeued entry, including we=0 entries (rd=x0, non-writing instructions, illegal load). It wraps at 2^RET_W.
- Entries leave in program order; no reordering.

Decomposition:
- Package wb_pkg holds:
  - WB_ALU/WB_LOAD/WB_PC4/WB_IMM encodings;
  - F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU constants;
  - the queue-entry struct {we, rd, data}.
- One combinational sub-module, wb_load_align, takes funct3, offset and word, and returns data plus a legal flag.
- The FIFO and output register stay inline.

Test Plan:
- Reset then single ALU op: rd=5, alu=0x1234, sel=00 → in_ready=1 after reset; rf_we=1, waddr=5, wdata=0x00001234 two edges after accept; retire_count=1.
- Load extension: word 0x80FF7F01.
  - LB offset 2 → 0xFFFFFFFF.
  - LBU offset 3 → 0x00000080.
  - LH offset 2 → 0xFFFF80FF.
  - LHU offset 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- x0 and illegal funct3: rd=0 with sel=ALU, then funct3=011 with sel=LOAD → rf_we stays 0 both times; retire_count rises by 2.
- Stall/backpressure: hold rf_stall=1, issue 5 ops with Q_DEPTH=4 → in_ready=0 after the 4th; q_level=4; release → 4 writes in order on consecutive cycles, then the 5th is accepted.
- Full plus simultaneous pop and push: level=4, stall drops while in_valid=1 → no enqueue that cycle; next cycle enqueue and dequeue together keep level at 3.
- Reset mid-run: 3 queued entries, rst=0 for one edge → rf_we=0, q_level=0, retire_count=0; queued entries never written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings and the retire-queue entry layout for the write-back stage.
package wb_pkg;
    localparam int WB_XLEN  = 32;
    localparam int WB_RF_AW = 5;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Field widths follow WB_XLEN / WB_RF_AW; the top uses them as defaults.
    typedef struct packed {
        logic                  we;
        logic [WB_RF_AW-1:0]   rd;
        logic [WB_XLEN-1:0]    data;
    } wb_entry_t;
endpackage

// File: rtl/wb_load_align.sv
// Picks the addressed byte/half out of a loaded word and extends it per funct3.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        legal
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'h00;
        case (offset)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = 8'h00;
        endcase
        // offset[0] is ignored for halves; misaligned halves are trapped earlier.
        lane_h = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data  = 32'h0;
        legal = 1'b1;
        case (funct3)
            F3_LB:   data = {{24{lane_b[7]}}, lane_b};
            F3_LH:   data = {{16{lane_h[15]}}, lane_h};
            F3_LW:   data = word;
            F3_LBU:  data = {24'h0, lane_b};
            F3_LHU:  data = {16'h0, lane_h};
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/wb_stage_q.sv
// Write-back stage: result select, retire FIFO, registered RF write/forward port
// and a retired-instruction counter.
module wb_stage_q
    import wb_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int RF_AW   = WB_RF_AW,
    parameter int Q_DEPTH = 4,
    parameter int RET_W   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RF_AW-1:0]           in_rd,
    input  logic                       in_reg_write,
    input  logic [1:0]                 in_wb_sel,
    input  logic [XLEN-1:0]            in_alu_result,
    input  logic [XLEN-1:0]            in_load_data,
    input  logic [2:0]                 in_ld_funct3,
    input  logic [1:0]                 in_ld_offset,
    input  logic [XLEN-1:0]            in_pc_plus4,
    input  logic [XLEN-1:0]            in_imm,
    input  logic                       rf_stall,
    output logic                       rf_we,
    output logic [RF_AW-1:0]           rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       fwd_valid,
    output logic [RF_AW-1:0]           fwd_rd,
    output logic [XLEN-1:0]            fwd_data,
    output logic [$clog2(Q_DEPTH):0]   q_level,
    output logic [RET_W-1:0]           retire_count
);
    localparam int PW = $clog2(Q_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(Q_DEPTH);

    wb_entry_t          mem [Q_DEPTH];
    wb_entry_t          entry;
    wb_entry_t          head;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level;
    logic [XLEN-1:0]    ld_data;
    logic               ld_legal;
    logic               push, pop;

    wb_load_align u_align (
        .funct3 (in_ld_funct3),
        .offset (in_ld_offset),
        .word   (in_load_data),
        .data   (ld_data),
        .legal  (ld_legal)
    );

    always_comb begin
        entry    = '0;
        entry.rd = in_rd;
        case (in_wb_sel)
            WB_ALU:  entry.data = in_alu_result;
            WB_LOAD: entry.data = ld_data;
            WB_PC4:  entry.data = in_pc_plus4;
            default: entry.data = in_imm;
        endcase
        entry.we = in_reg_write && (in_rd != '0) && ((in_wb_sel != WB_LOAD) || ld_legal);
    end

    // Readiness uses the current level only, so a full queue refuses even while popping.
    assign in_ready = rst && (level != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (level != '0) && !rf_stall;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            retire_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                rf_we        <= head.we;
                rf_waddr     <= head.rd;
                rf_wdata     <= head.data;
                retire_count <= retire_count + RET_W'(1);
            end else begin
                rf_we <= 1'b0;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign q_level   = level;
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;
endmodule
